// File: rtl/ysyx_23060111_mdu.sv
// rtl/ysyx_23060111_mdu.sv - iterative RV32M multiply/divide unit
module ysyx_23060111_mdu #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [4:0]      in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd
);

  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [2:0]          r_f3;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_acc;     // multiply: product/multiplier; divide: low half is quotient/dividend
  logic [XLEN-1:0]     r_b;
  logic [XLEN:0]       r_rem;
  logic                r_neg_q, r_neg_r;

  logic                w_accept, w_is_div, w_sa, w_sb;
  logic                w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0]     w_mag_a, w_mag_b, w_special_res, w_min;
  logic [2*XLEN-1:0]   w_mul_nxt, w_prod;
  logic [XLEN:0]       w_sum, w_rem_nxt, w_trial;
  logic [XLEN-1:0]     w_quo_nxt, w_quo, w_rmd, w_fix_res;

  assign w_min     = {1'b1, {(XLEN-1){1'b0}}};
  assign in_ready  = ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready)) & ~flush;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == S_DONE);

  // Operand signs, magnitudes and the divide special cases for the incoming op
  always_comb begin
    w_is_div      = in_funct3[2];
    w_sa          = in_src1[XLEN-1] & (w_is_div ? ~in_funct3[0]
                                                : (in_funct3[1:0] == 2'b01) | (in_funct3[1:0] == 2'b10));
    w_sb          = in_src2[XLEN-1] & (w_is_div ? ~in_funct3[0] : (in_funct3[1:0] == 2'b01));
    w_mag_a       = w_sa ? ('0 - in_src1) : in_src1;
    w_mag_b       = w_sb ? ('0 - in_src2) : in_src2;
    w_div_zero    = w_is_div & (in_src2 == '0);
    w_div_ovf     = w_is_div & ~in_funct3[0] & (in_src1 == w_min) & (in_src2 == '1);
    w_special     = w_div_zero | w_div_ovf;
    w_special_res = w_div_zero ? (in_funct3[1] ? in_src1 : '1) : (in_funct3[1] ? '0 : w_min);
  end

  // One CALC cycle: BPC shift-add steps and BPC restoring-divide steps
  always_comb begin
    w_mul_nxt = r_acc;
    w_rem_nxt = r_rem;
    w_quo_nxt = r_acc[XLEN-1:0];
    w_sum     = '0;
    w_trial   = '0;
    for (int i = 0; i < BPC; i++) begin
      w_sum     = {1'b0, w_mul_nxt[2*XLEN-1:XLEN]} + (w_mul_nxt[0] ? {1'b0, r_b} : '0);
      w_mul_nxt = {w_sum, w_mul_nxt[XLEN-1:1]};
      w_rem_nxt = {w_rem_nxt[XLEN-1:0], w_quo_nxt[XLEN-1]};
      w_trial   = w_rem_nxt - {1'b0, r_b};
      w_quo_nxt = {w_quo_nxt[XLEN-2:0], ~w_trial[XLEN]};
      if (!w_trial[XLEN]) w_rem_nxt = w_trial;
    end
  end

  // Sign correction and result selection in FIX
  always_comb begin
    w_prod = r_neg_q ? ('0 - r_acc) : r_acc;
    w_quo  = r_neg_q ? ('0 - r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
    w_rmd  = r_neg_r ? ('0 - r_rem[XLEN-1:0]) : r_rem[XLEN-1:0];
    if (r_f3[2])                 w_fix_res = r_f3[1] ? w_rmd : w_quo;
    else if (r_f3[1:0] == 2'b00) w_fix_res = w_prod[XLEN-1:0];
    else                         w_fix_res = w_prod[2*XLEN-1:XLEN];
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
        S_CALC: if (r_cnt == LAST) w_next = S_FIX;
        S_FIX:  w_next = S_DONE;
        S_DONE: if (out_ready) w_next = w_accept ? (w_special ? S_DONE : S_CALC) : S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Datapath: load on accept, iterate in CALC, register result in FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f3       <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_b        <= '0;
      r_rem      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
    end else if (w_accept) begin
      r_f3    <= in_funct3;
      out_rd  <= in_rd;
      r_cnt   <= '0;
      r_acc   <= {{XLEN{1'b0}}, w_mag_a};
      r_b     <= w_mag_b;
      r_rem   <= '0;
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
      if (w_special) out_result <= w_special_res;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt + CW'(1);
      r_acc <= r_f3[2] ? {r_acc[2*XLEN-1:XLEN], w_quo_nxt} : w_mul_nxt;
      if (r_f3[2]) r_rem <= w_rem_nxt;
    end else if ((r_state == S_FIX) && !flush) begin
      out_result <= w_fix_res;
    end
  end

endmodule

// File: doc/ysyx_23060111_mdu.md
# ysyx_23060111_mdu

Iterative RV32M multiply/divide unit with a parametrised datapath width and a configurable number of result bits produced per cycle. It sits beside the single-cycle execute ALU and takes opcode `0110011` with `funct7 = 0000001`. It accepts one operation at a time through a valid/ready handshake and returns the `rd` write-back value with its destination tag. It supports a pipeline flush.

## Interface
- `XLEN`, 32: operand and result width.
- `BPC`, 1: quotient/product bits retired per cycle. Legal values are 1, 2 and 4, and `BPC` must divide `XLEN`. N = `XLEN`/`BPC`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operation offered.
- `in_ready` output 1: unit can accept.
- `in_funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `in_src1` input `XLEN`: rs1 value.
- `in_src2` input `XLEN`: rs2 value.
- `in_rd` input 5: destination tag, passed through.
- `flush` input 1: kill any in-flight operation.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes result.
- `out_result` output `XLEN`: `rd` write data.
- `out_rd` output 5: tag of the result.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- **IDLE → CALC** on accept, where accept = `in_valid & in_ready & !flush`.
  - Latch `funct3` and `rd`.
  - Convert signed operands to magnitudes and record the result sign. MULH signs both operands, MULHSU signs `src1` only, DIV/REM sign both.
  - The magnitude of the most-negative value is held as an unsigned `XLEN`-bit value.
  - Clear the iteration counter (width clog2(N+1)).
- **CALC** lasts exactly N cycles, retiring `BPC` bits per cycle.
  - Multiply: shift-add into a 2·`XLEN` accumulator.
  - Divide: restoring divide with an `XLEN+1`-bit partial remainder.
  - CALC → FIX when the counter reaches N−1.
- **FIX** lasts one cycle.
  - Negate where required. The quotient sign is sign(a)^sign(b); the remainder takes the sign of the dividend.
  - Select the result: low half for MUL, high half for MULH*, quotient for DIV*, remainder for REM*.
  - Register the result into `out_result`, then go to DONE.
- **Special cases (signed and unsigned divide/remainder)**: these bypass CALC and FIX, going IDLE → DONE with the result registered directly.
  - Divide by zero: quotient = all-ones, remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = most-negative, remainder = 0.
- **DONE**: `out_valid` = 1. `out_result` and `out_rd` are held stable until `out_valid & out_ready`.
  - On handshake, go to IDLE. If a new accept happens in the same cycle, go straight to CALC (or DONE for a special case) instead.
- `in_ready` = (state == IDLE) | (state == DONE & `out_ready`), gated by `!flush`.
- **Flush**: in any state, the next state is IDLE and `out_valid` drops on the next edge. A flush asserted in the same cycle as `in_valid` prevents acceptance. The result of a flushed operation is never presented.
- All arithmetic is modulo 2^`XLEN` on results. No exceptions are raised.

## Timing
- **Reset** (asynchronous, immediate): state = IDLE, `out_valid` = 0, `out_result` = 0, `out_rd` = 0, counter = 0. `in_ready` reads 1 while reset is deasserted and `flush` = 0.
- **Normal latency**: accept in cycle 0; CALC in cycles 1..N; FIX in cycle N+1; `out_valid` = 1 from cycle N+2. With `XLEN` = 32 and `BPC` = 1 this is cycle 34; with `BPC` = 4 it is cycle 10.
- **Special-case latency**: `out_valid` = 1 in cycle 1.
- **Throughput**: one operation per N+2 cycles when `out_ready` is held high, because accept in DONE overlaps the output handshake.
- **Reset mid-operation**: the in-flight operation is discarded and outputs return to their reset values without waiting for a clock edge.

## Test plan
- **Multiply, low word**: MUL 7 × 0xFFFFFFFD → `out_result` 0xFFFFFFEB with `out_rd` equal to the issued tag. `out_valid` first high in cycle 34 (`BPC` = 1), then repeat with `BPC` = 4 and expect cycle 10.
- **High-half multiplies**:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- **Divide and remainder**:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 7 / 2 → 3; REMU 7 / 2 → 1.
- **Special cases**, each with `out_valid` in cycle 1:
  - DIV 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- **Backpressure**: hold `out_ready` = 0 for 5 cycles in DONE → result and tag stable, `in_ready` = 0. Then assert `out_ready` with `in_valid` in the same cycle → new operation accepted that cycle, next result correct.
- **Flush and reset**:
  - Flush in cycle 10 of CALC → `out_valid` never rises and `in_ready` = 1 next cycle. A following MUL 3 × 4 returns 12.
  - Assert `rst_n` = 0 mid-CALC → `out_valid` and `out_result` go to 0 immediately.
